vuprs_adc_sample_scheduler: RTL and testbench

Sequences the two AD7606 controllers (ADC-A, ADC-B) from a single programmable sample clock, replacing the free-running trigger toggle. Issues a shared rising-edge trigger only when both controllers are ready and idle, then tracks both conversions to completion. Emits a frame-valid strobe with a sample index, counts missed sample ticks (overruns), supports finite bursts, and latches fault conditions. Sits between the system configuration registers and both ad7606 instances.

---
 rtl/vuprs_adc_sample_scheduler_if.sv | 40 ++++
 rtl/vuprs_adc_sample_scheduler.sv | 178 +++++++++++++++++
 tb/tb_vuprs_adc_sample_scheduler.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vuprs_adc_sample_scheduler_if.sv
// Configuration, AD7606 controller status and scheduler results bundled as one port.
// The master modport drives config and ADC status; the slave modport is the scheduler.
interface vuprs_adc_sample_scheduler_if #(
    parameter int PERIOD_W = 24,
    parameter int CNT_W    = 16
);
    logic                cfg_enable;
    logic [PERIOD_W-1:0] cfg_period;
    logic [CNT_W-1:0]    cfg_burst_len;
    logic                adc_ready_a;
    logic                adc_ready_b;
    logic                adc_sampling_a;
    logic                adc_sampling_b;
    logic [3:0]          adc_error_a;
    logic [3:0]          adc_error_b;
    logic                trig;
    logic                frame_valid;
    logic [31:0]         frame_index;
    logic [CNT_W-1:0]    overrun_count;
    logic                burst_done;
    logic                running;
    logic [2:0]          sched_error;
    logic [31:0]         frame_timestamp;

    modport master (
        output cfg_enable, cfg_period, cfg_burst_len,
        output adc_ready_a, adc_ready_b, adc_sampling_a, adc_sampling_b,
        output adc_error_a, adc_error_b,
        input  trig, frame_valid, frame_index, overrun_count, burst_done,
        input  running, sched_error, frame_timestamp
    );

    modport slave (
        input  cfg_enable, cfg_period, cfg_burst_len,
        input  adc_ready_a, adc_ready_b, adc_sampling_a, adc_sampling_b,
        input  adc_error_a, adc_error_b,
        output trig, frame_valid, frame_index, overrun_count, burst_done,
        output running, sched_error, frame_timestamp
    );
endinterface

// File: rtl/vuprs_adc_sample_scheduler.sv
// Paced shared trigger for two AD7606 controllers with frame, overrun, burst and fault tracking.
// Trig one cycle after an accepted tick; busy ADCs turn ticks into overruns. VUPRS_ADC_SCHED_TIMESTAMP_EN adds timestamps.
module vuprs_adc_sample_scheduler #(
    parameter int PERIOD_W      = 24,
    parameter int MIN_PERIOD    = 100,
    parameter int TRIG_HIGH     = 4,
    parameter int START_TIMEOUT = 64,
    parameter int DONE_TIMEOUT  = 512,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    vuprs_adc_sample_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_READY, S_ARM, S_TRIG, S_WAIT_START, S_WAIT_DONE, S_FRAME, S_ERROR
    } state_t;

    localparam int TMR_W = 16;
    localparam logic [TMR_W-1:0]    TRIG_LAST  = TMR_W'(TRIG_HIGH - 1);
    localparam logic [TMR_W-1:0]    START_LAST = TMR_W'(START_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]    DONE_LIMIT = TMR_W'(DONE_TIMEOUT);
    localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);

    state_t              state, state_n;
    logic [2:0]          err_q, err_n;
    logic                en_q;
    logic [PERIOD_W-1:0] eff_period, period_cnt;
    logic [CNT_W-1:0]    burst_len, frame_cnt, overrun_cnt;
    logic [TMR_W-1:0]    tmr;
    logic                seen_a_q, seen_b_q;
    logic [31:0]         frame_idx;

    logic en_rise, in_conv, cnt_run, tick, adc_err, ready_ok, busy, seen_a, seen_b, last_frame;

    assign en_rise    = bus.cfg_enable & ~en_q;
    assign in_conv    = state inside {S_TRIG, S_WAIT_START, S_WAIT_DONE, S_FRAME};
    assign cnt_run    = (state == S_ARM) || in_conv;
    assign tick       = cnt_run && (period_cnt == eff_period - 1'b1);
    assign adc_err    = |{bus.adc_error_a, bus.adc_error_b};
    assign ready_ok   = bus.adc_ready_a & bus.adc_ready_b;
    assign busy       = bus.adc_sampling_a | bus.adc_sampling_b;
    assign seen_a     = seen_a_q | bus.adc_sampling_a;
    assign seen_b     = seen_b_q | bus.adc_sampling_b;
    assign last_frame = (burst_len != '0) && (frame_cnt + 1'b1 == burst_len);

    always_comb begin
        state_n = state;
        err_n   = err_q;
        case (state)
            S_IDLE:       if (en_rise) state_n = S_WAIT_READY;
            S_WAIT_READY: if (ready_ok) state_n = S_ARM;
            S_ARM:        if (tick && !busy) state_n = S_TRIG;
            S_TRIG:       if (tmr == TRIG_LAST) state_n = S_WAIT_START;
            S_WAIT_START: begin
                if (seen_a && seen_b) begin
                    state_n = S_WAIT_DONE;
                end else if (tmr == START_LAST) begin
                    state_n = S_ERROR;
                    err_n   = 3'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!busy) begin
                    state_n = S_FRAME;
                end else if (tmr == DONE_LIMIT) begin
                    state_n = S_ERROR;
                    err_n   = 3'd2;
                end
            end
            S_FRAME:      state_n = last_frame ? S_IDLE : S_ARM;
            S_ERROR: begin
                if (!bus.cfg_enable) begin
                    state_n = S_IDLE;
                    err_n   = 3'd0;
                end
            end
            default:      state_n = S_IDLE;
        endcase
        // Abort beats faults, controller error flags beat lost ready, both beat timeouts.
        if (state != S_IDLE && state != S_ERROR) begin
            if (!bus.cfg_enable) begin
                state_n = S_IDLE;
            end else if (adc_err) begin
                state_n = S_ERROR;
                err_n   = 3'd3;
            end else if (state != S_WAIT_READY && !ready_ok) begin
                state_n = S_ERROR;
                err_n   = 3'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            err_q       <= 3'd0;
            en_q        <= 1'b0;
            eff_period  <= MIN_P;
            period_cnt  <= '0;
            burst_len   <= '0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
            tmr         <= '0;
            seen_a_q    <= 1'b0;
            seen_b_q    <= 1'b0;
            frame_idx   <= '0;
        end else begin
            state <= state_n;
            err_q <= err_n;
            en_q  <= bus.cfg_enable;

            // The start timer keeps counting across TRIG into WAIT_START.
            if (state_n != state && !(state == S_TRIG && state_n == S_WAIT_START))
                tmr <= '0;
            else
                tmr <= tmr + 1'b1;

            if (!cnt_run || tick)
                period_cnt <= '0;
            else
                period_cnt <= period_cnt + 1'b1;

            if (state == S_ARM) begin
                seen_a_q <= 1'b0;
                seen_b_q <= 1'b0;
            end else if (state == S_TRIG || state == S_WAIT_START) begin
                seen_a_q <= seen_a;
                seen_b_q <= seen_b;
            end

            if (state == S_IDLE && en_rise) begin
                eff_period  <= (bus.cfg_period < MIN_P) ? MIN_P : bus.cfg_period;
                burst_len   <= bus.cfg_burst_len;
                frame_cnt   <= '0;
                frame_idx   <= '0;
                overrun_cnt <= '0;
            end else begin
                if (tick && (in_conv || busy) && overrun_cnt != '1)
                    overrun_cnt <= overrun_cnt + 1'b1;
                if (state == S_FRAME) begin
                    frame_idx <= frame_idx + 32'd1;
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

`ifdef VUPRS_ADC_SCHED_TIMESTAMP_EN
    logic [31:0] cyc_cnt, trig_ts, stamp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt <= '0;
            trig_ts <= '0;
            stamp   <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (state == S_TRIG && tmr == '0)
                trig_ts <= cyc_cnt;
            if (state_n == S_FRAME)
                stamp <= trig_ts;
        end
    end

    assign bus.frame_timestamp = stamp;
`else
    assign bus.frame_timestamp = 32'd0;
`endif

    assign bus.trig          = (state == S_TRIG) && bus.cfg_enable;
    assign bus.frame_valid   = (state == S_FRAME);
    assign bus.burst_done    = (state == S_FRAME) && last_frame;
    assign bus.running       = (state != S_IDLE) && (state != S_ERROR);
    assign bus.sched_error   = err_q;
    assign bus.frame_index   = frame_idx;
    assign bus.overrun_count = overrun_cnt;
endmodule

// File: tb/tb_vuprs_adc_sample_scheduler.sv
// Bench for the ADC sample scheduler: reactive AD7606 model plus a tick-grid reference model.
module tb_vuprs_adc_sample_scheduler;
    logic clk;
    logic rst;

    vuprs_adc_sample_scheduler_if #(.PERIOD_W(24), .CNT_W(16)) ifc ();

    vuprs_adc_sample_scheduler #(.PERIOD_W(24), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int rise_cyc = -100000;
    int hi_cnt = 0;
    int hi_last = 0;
    bit trig_q = 1'b0;
    bit rise = 1'b0;
    bit fall = 1'b0;
    bit b_en = 1'b1;
    int sa, sb, la, lb;
    int exp_r[16];
    int exp_f[16];
    int exp_o[16];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One clock: observe outputs, then drive the ADC model for this cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rise = ifc.trig && !trig_q;
        fall = !ifc.trig && trig_q;
        if (fall) hi_last = hi_cnt;
        hi_cnt = ifc.trig ? hi_cnt + 1 : 0;
        trig_q = ifc.trig;
        if (rise) rise_cyc = cyc;
        ifc.adc_sampling_a = (cyc >= rise_cyc + sa) && (cyc < rise_cyc + sa + la);
        ifc.adc_sampling_b = b_en && (cyc >= rise_cyc + sb) && (cyc < rise_cyc + sb + lb);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_rise(output int rc);
        rc = -1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (rise) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) chk("rise_timeout", 0, 1);
    endtask

    task automatic do_run(input int p_cfg, input int burst);
        int p, nfr, e, kr, kf, limit, t, ovr, pend, r, w, z, f, n_after;
        longint exp_ts;
        p   = (p_cfg < 100) ? 100 : p_cfg;
        nfr = (burst == 0) ? 4 : burst;
        ifc.cfg_period    = 24'(p_cfg);
        ifc.cfg_burst_len = 16'(burst);
        ifc.cfg_enable    = 1'b1;
        e = cyc;
        // Reference: accepted ticks lie on a grid of period p; ticks landing while
        // a conversion is in flight (trig rise .. frame strobe) are overruns.
        r = e + p + 2;
        ovr = 0;
        for (int k = 0; k < nfr; k++) begin
            exp_r[k] = r;
            w = imax(r + 4, imax(r + sa, r + sb));
            z = imax(r + sa + la, r + sb + lb);
            f = imax(w + 1, z) + 1;
            exp_f[k] = f;
            pend = 0;
            t = r - 1 + p;
            while (t <= f) begin
                if (t < f) ovr++;
                else pend++;
                t += p;
            end
            exp_o[k] = ovr;
            ovr += pend;
            r = t + 1;
        end
        kr = 0;
        kf = 0;
        limit = e + nfr * (4 * p + 700) + p + 100;
        step();
        ifc.cfg_period = 24'($urandom_range(1, 1000));
        while (kf < nfr && cyc < limit) begin
            if (rise) begin
                if (kr < nfr) chk("trig_rise", longint'(cyc), longint'(exp_r[kr]));
                else chk("extra_trig", 1, 0);
                kr++;
            end
            if (fall) chk("trig_width", longint'(hi_last), 4);
            if (ifc.frame_valid) begin
`ifdef VUPRS_ADC_SCHED_TIMESTAMP_EN
                exp_ts = longint'(exp_r[kf]);
`else
                exp_ts = 0;
`endif
                chk("frame_cycle", longint'(cyc), longint'(exp_f[kf]));
                chk("frame_index", longint'(ifc.frame_index), longint'(kf));
                chk("overrun_at_frame", longint'(ifc.overrun_count), longint'(exp_o[kf]));
                chk("burst_done", longint'(ifc.burst_done), longint'(burst != 0 && kf == nfr - 1));
                chk("frame_ts", longint'(ifc.frame_timestamp), exp_ts);
                kf++;
            end else if (ifc.burst_done) begin
                chk("stray_burst_done", 1, 0);
            end
            if (kf < nfr) step();
        end
        chk("frames_seen", longint'(kf), longint'(nfr));
        if (burst == 0) begin
            ifc.cfg_enable = 1'b0;
            step();
            chk("running_after_stop", longint'(ifc.running), 0);
            chk("overrun_total", longint'(ifc.overrun_count), longint'(ovr));
        end else begin
            step();
            chk("running_after_burst", longint'(ifc.running), 0);
            n_after = 0;
            repeat (3 * p) begin
                step();
                if (rise || ifc.frame_valid) n_after++;
            end
            chk("quiet_after_burst", longint'(n_after), 0);
            ifc.cfg_enable = 1'b0;
        end
        idle(600);
    endtask

    initial begin
        int rc, p_cfg, burst;
        rst = 1'b0;
        ifc.cfg_enable     = 1'b0;
        ifc.cfg_period     = 24'd0;
        ifc.cfg_burst_len  = 16'd0;
        ifc.adc_ready_a    = 1'b1;
        ifc.adc_ready_b    = 1'b1;
        ifc.adc_sampling_a = 1'b0;
        ifc.adc_sampling_b = 1'b0;
        ifc.adc_error_a    = 4'h0;
        ifc.adc_error_b    = 4'h0;
        sa = 1; sb = 1; la = 200; lb = 200;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_trig", longint'(ifc.trig), 0);
        chk("rst_frame_valid", longint'(ifc.frame_valid), 0);
        chk("rst_frame_index", longint'(ifc.frame_index), 0);
        chk("rst_overrun", longint'(ifc.overrun_count), 0);
        chk("rst_burst_done", longint'(ifc.burst_done), 0);
        chk("rst_running", longint'(ifc.running), 0);
        chk("rst_sched_error", longint'(ifc.sched_error), 0);
        chk("rst_timestamp", longint'(ifc.frame_timestamp), 0);
        rst = 1'b1;
        idle(5);

        // Continuous, overrun-every-frame, clamped burst, then randomized runs.
        sa = 1; sb = 1; la = 200; lb = 200;
        do_run(333, 0);
        sa = 2; sb = 3; la = 250; lb = 240;
        do_run(150, 0);
        sa = 1; sb = 2; la = 60; lb = 70;
        do_run(10, 5);
        for (int i = 0; i < 5; i++) begin
            sa = $urandom_range(1, 8);
            sb = $urandom_range(1, 8);
            la = $urandom_range(20, 400);
            lb = $urandom_range(20, 400);
            p_cfg = $urandom_range(20, 320);
            burst = $urandom_range(0, 4);
            do_run(p_cfg, burst);
        end

        // Start timeout: channel B never starts sampling.
        sa = 2; la = 100; b_en = 1'b0;
        ifc.cfg_period = 24'd100;
        ifc.cfg_burst_len = 16'd0;
        ifc.cfg_enable = 1'b1;
        wait_rise(rc);
        while (cyc < rc + 63) step();
        chk("start_to_pre", longint'(ifc.sched_error), 0);
        step();
        chk("start_to_code", longint'(ifc.sched_error), 1);
        chk("start_to_trig", longint'(ifc.trig), 0);
        chk("start_to_running", longint'(ifc.running), 0);
        ifc.cfg_enable = 1'b0;
        step();
        chk("err_cleared", longint'(ifc.sched_error), 0);
        chk("err_idle", longint'(ifc.running), 0);
        idle(300);

        // Controller error in the same cycle the start timeout would fire.
        ifc.cfg_enable = 1'b1;
        wait_rise(rc);
        while (cyc < rc + 63) step();
        ifc.adc_error_a = 4'h2;
        step();
        chk("err_priority", longint'(ifc.sched_error), 3);
        ifc.adc_error_a = 4'h0;
        ifc.cfg_enable = 1'b0;
        idle(300);

        // Controller error while waiting for conversions to finish.
        b_en = 1'b1; sa = 2; sb = 2; la = 200; lb = 200;
        ifc.cfg_enable = 1'b1;
        wait_rise(rc);
        while (cyc < rc + 50) step();
        ifc.adc_error_a = 4'h2;
        step();
        chk("err_wait_done", longint'(ifc.sched_error), 3);
        chk("err_wait_done_trig", longint'(ifc.trig), 0);
        ifc.adc_error_a = 4'h0;
        ifc.cfg_enable = 1'b0;
        idle(400);

        // Ready lost mid-run.
        ifc.cfg_enable = 1'b1;
        idle(20);
        ifc.adc_ready_b = 1'b0;
        step();
        chk("ready_drop_code", longint'(ifc.sched_error), 4);
        chk("ready_drop_running", longint'(ifc.running), 0);
        ifc.adc_ready_b = 1'b1;
        ifc.cfg_enable = 1'b0;
        idle(10);

        // Enable dropped while trig is high.
        ifc.cfg_enable = 1'b1;
        wait_rise(rc);
        step();
        chk("abort_trig_before", longint'(ifc.trig), 1);
        ifc.cfg_enable = 1'b0;
        #1;
        chk("abort_trig_now", longint'(ifc.trig), 0);
        step();
        chk("abort_running", longint'(ifc.running), 0);
        rc = 0;
        repeat (500) begin
            step();
            if (ifc.frame_valid) rc++;
        end
        chk("abort_no_frame", longint'(rc), 0);
        chk("abort_no_error", longint'(ifc.sched_error), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
